// File: rtl/axi2mem_rd_resp_buffer.sv
// Read-side AXI-to-memory adapter: credit-limited 64-bit reads with
// an in-order response buffer and a matching ID/last tag queue.
module axi2mem_rd_resp_buffer #(
  parameter int DEPTH      = 4,
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               trans_req_i,
  input  logic [1:0][31:0]         trans_add_i,
  input  logic [1:0][ID_WIDTH-1:0] trans_id_i,
  input  logic [1:0]               trans_last_i,
  output logic [1:0]               trans_gnt_o,
  output logic                     mem_req_o,
  output logic [ADDR_WIDTH-1:0]    mem_add_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_r_valid_i,
  input  logic [63:0]              mem_r_rdata_i,
  output logic [63:0]              data_dat_o,
  output logic [ID_WIDTH-1:0]      data_id_o,
  output logic                     data_last_o,
  output logic                     data_gnt_o,
  input  logic                     data_req_i,
  output logic                     err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                last;
  } tag_t;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] inflight;
  logic [PW:0]   tag_wr;
  logic [PW:0]   tag_rd;
  logic [PW:0]   dat_wr;
  logic [PW:0]   dat_rd;
  tag_t          tag_mem [DEPTH];
  logic [63:0]   dat_mem [DEPTH];

  logic credit_ok;
  logic accept;
  logic rsp_ok;
  logic stray;
  logic pop;
  logic dat_empty;
  tag_t tag_in;
  tag_t tag_head;

  assign credit_ok = outstanding < CW'(DEPTH);
  assign trans_gnt_o = {2{mem_gnt_i & credit_ok}};
  assign mem_req_o = (trans_req_i == 2'b11) & credit_ok;
  assign mem_add_o = {trans_add_i[0][ADDR_WIDTH-1:3], 3'b000};
  assign accept = mem_req_o & mem_gnt_i;

  assign rsp_ok = mem_r_valid_i & (inflight != '0);
  assign stray  = mem_r_valid_i & (inflight == '0);

  assign dat_empty  = (dat_wr == dat_rd);
  assign data_gnt_o = ~dat_empty;
  assign pop        = data_req_i & data_gnt_o;

  assign tag_in.id   = trans_id_i[0];
  assign tag_in.last = trans_last_i[0];

  assign tag_head    = tag_mem[tag_rd[PW-1:0]];
  assign data_dat_o  = dat_mem[dat_rd[PW-1:0]];
  assign data_id_o   = tag_head.id;
  assign data_last_o = tag_head.last;

  logic unused_bits;
  assign unused_bits = ^{trans_add_i[1], trans_add_i[0][2:0],
                         trans_id_i[1], trans_last_i[1]};

  // credit is released only by a pop, so a pop cannot re-grant in-cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
      inflight    <= '0;
      err_o       <= 1'b0;
    end else begin
      unique case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      unique case ({accept, rsp_ok})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (stray) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_wr <= '0;
      tag_rd <= '0;
      for (int i = 0; i < DEPTH; i++) tag_mem[i] <= '0;
    end else begin
      if (accept) begin
        tag_mem[tag_wr[PW-1:0]] <= tag_in;
        tag_wr <= tag_wr + (PW+1)'(1);
      end
      if (pop) tag_rd <= tag_rd + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_wr <= '0;
      dat_rd <= '0;
      for (int i = 0; i < DEPTH; i++) dat_mem[i] <= '0;
    end else begin
      if (rsp_ok) begin
        dat_mem[dat_wr[PW-1:0]] <= mem_r_rdata_i;
        dat_wr <= dat_wr + (PW+1)'(1);
      end
      if (pop) dat_rd <= dat_rd + (PW+1)'(1);
    end
  end

endmodule

// File: tb/tb_axi2mem_rd_resp_buffer.sv
// Directed bench for axi2mem_rd_resp_buffer with a fixed-latency
// memory model that can be swapped for hand-driven responses.
module tb_axi2mem_rd_resp_buffer;

  logic             clk;
  logic             rst;
  logic [1:0]       trans_req;
  logic [1:0][31:0] trans_add;
  logic [1:0][5:0]  trans_id;
  logic [1:0]       trans_last;
  logic [1:0]       trans_gnt;
  logic             mem_req;
  logic [31:0]      mem_add;
  logic             mem_gnt;
  wire              mem_r_valid;
  wire  [63:0]      mem_r_rdata;
  logic [63:0]      data_dat;
  logic [5:0]       data_id;
  logic             data_last;
  logic             data_gnt;
  logic             data_req;
  logic             err;

  logic             model_en;
  int               lat;
  logic             man_valid;
  logic [63:0]      man_data;
  logic             mdl_valid;
  logic [63:0]      mdl_data;

  int checks;
  int failures;

  assign mem_r_valid = model_en ? mdl_valid : man_valid;
  assign mem_r_rdata = model_en ? mdl_data : man_data;

  axi2mem_rd_resp_buffer #(
    .DEPTH(4), .ID_WIDTH(6), .ADDR_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .trans_req_i(trans_req), .trans_add_i(trans_add),
    .trans_id_i(trans_id), .trans_last_i(trans_last),
    .trans_gnt_o(trans_gnt),
    .mem_req_o(mem_req), .mem_add_o(mem_add), .mem_gnt_i(mem_gnt),
    .mem_r_valid_i(mem_r_valid), .mem_r_rdata_i(mem_r_rdata),
    .data_dat_o(data_dat), .data_id_o(data_id),
    .data_last_o(data_last), .data_gnt_o(data_gnt),
    .data_req_i(data_req), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: an accept in cycle T answers in cycle T+lat with
  // data {32'hC0DE0000, address}.
  logic        slot_v [8];
  logic [63:0] slot_d [8];
  initial begin
    logic        acc_s;
    logic [31:0] add_s;
    mdl_valid = 1'b0;
    mdl_data  = '0;
    for (int i = 0; i < 8; i++) begin
      slot_v[i] = 1'b0;
      slot_d[i] = '0;
    end
    forever begin
      @(negedge clk);
      acc_s = mem_req & mem_gnt & ~rst;
      add_s = mem_add;
      @(posedge clk);
      #1;
      if (rst || !model_en) begin
        for (int i = 0; i < 8; i++) slot_v[i] = 1'b0;
        mdl_valid = 1'b0;
      end else begin
        if (acc_s) begin
          slot_v[lat-1] = 1'b1;
          slot_d[lat-1] = {32'hC0DE0000, add_s};
        end
        mdl_valid = slot_v[0];
        mdl_data  = slot_d[0];
        for (int i = 0; i < 7; i++) begin
          slot_v[i] = slot_v[i+1];
          slot_d[i] = slot_d[i+1];
        end
        slot_v[7] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && dut.outstanding > 3'd4) begin
      $display("FAIL overflow outstanding=%0d limit=4", dut.outstanding);
      failures++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_trans(input logic [1:0] req, input logic [31:0] a,
                           input logic [5:0] id, input logic last);
    trans_req  = req;
    trans_add  = {32'h0, a};
    trans_id   = {6'h0, id};
    trans_last = {1'b0, last};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_gnt = 1'b1;
    set_trans(2'b00, 32'h0, 6'h0, 1'b0);
    data_req = 1'b0;
    #3;
    checks++;
    if (trans_gnt !== 2'b11) begin
      $display("FAIL rst_gnt got=%b exp=11", trans_gnt); failures++;
    end
    checks++;
    if (data_gnt !== 1'b0 || data_dat !== 64'h0 || data_id !== 6'h0
        || data_last !== 1'b0 || err !== 1'b0) begin
      $display("FAIL rst_out got=%b %h %h %b %b exp=0", data_gnt,
               data_dat, data_id, data_last, err);
      failures++;
    end
    trans_req = 2'b11;
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      $display("FAIL rst_memreq got=%b exp=1", mem_req); failures++;
    end
    trans_req = 2'b00;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    model_en = 1'b0;
    step();
    set_trans(2'b11, 32'h1004, 6'd5, 1'b1);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_add !== 32'h1000) begin
      $display("FAIL single_req got=%b %h exp=1 00001000", mem_req, mem_add);
      failures++;
    end
    step();
    trans_req = 2'b00;
    man_valid = 1'b1;
    man_data  = 64'hDEADBEEF_01234567;
    #1;
    checks++;
    if (data_gnt !== 1'b0) begin
      $display("FAIL single_early got=%b exp=0", data_gnt); failures++;
    end
    step();
    man_valid = 1'b0;
    #1;
    checks++;
    if (data_gnt !== 1'b1 || data_dat !== 64'hDEADBEEF_01234567
        || data_id !== 6'd5 || data_last !== 1'b1) begin
      $display("FAIL single_data got=%b %h %0d %b exp=1 deadbeef01234567 5 1",
               data_gnt, data_dat, data_id, data_last);
      failures++;
    end
    data_req = 1'b1;
    step();
    data_req = 1'b0;
    #1;
    checks++;
    if (data_gnt !== 1'b0 || err !== 1'b0) begin
      $display("FAIL single_pop got=%b %b exp=0 0", data_gnt, err);
      failures++;
    end
  endtask

  task automatic test_credit_stall();
    int acc;
    int pops;
    model_en = 1'b1;
    lat = 3;
    data_req = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      set_trans(2'b11, 32'h2000 + 32'(8*k), 6'd9, 1'b0);
      #1;
      if (mem_req && mem_gnt) acc++;
    end
    checks++;
    if (acc != 4) begin
      $display("FAIL credit_accepts got=%0d exp=4", acc); failures++;
    end
    checks++;
    if (trans_gnt !== 2'b00) begin
      $display("FAIL credit_gnt got=%b exp=00", trans_gnt); failures++;
    end
    step();
    data_req = 1'b1;
    #1;
    checks++;
    if (trans_gnt !== 2'b00 || data_dat !== 64'hC0DE0000_00002000
        || data_id !== 6'd9) begin
      $display("FAIL credit_pop got=%b %h %0d exp=00 c0de000000002000 9",
               trans_gnt, data_dat, data_id);
      failures++;
    end
    step();
    data_req = 1'b0;
    #1;
    checks++;
    if (trans_gnt !== 2'b11 || mem_req !== 1'b1) begin
      $display("FAIL credit_regrant got=%b %b exp=11 1", trans_gnt, mem_req);
      failures++;
    end
    step();
    trans_req = 2'b00;
    data_req = 1'b1;
    pops = 0;
    for (int i = 0; i < 20 && pops < 4; i++) begin
      #1;
      if (data_gnt) pops++;
      step();
    end
    data_req = 1'b0;
    #1;
    checks++;
    if (pops != 4 || data_gnt !== 1'b0 || trans_gnt !== 2'b11) begin
      $display("FAIL credit_drain got=%0d %b %b exp=4 0 11",
               pops, data_gnt, trans_gnt);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    int beats;
    int first;
    int prev;
    int gaps;
    logic [63:0] exp_d;
    model_en = 1'b1;
    lat = 1;
    data_req = 1'b1;
    beats = 0;
    first = -1;
    prev = -1;
    gaps = 0;
    step();
    for (int c = 0; c < 14; c++) begin
      if (c < 8) set_trans(2'b11, 32'h3000 + 32'(8*c), 6'd3, c == 7);
      else trans_req = 2'b00;
      #1;
      if (c < 8) begin
        checks++;
        if (mem_req !== 1'b1) begin
          $display("FAIL burst_req c=%0d got=%b exp=1", c, mem_req);
          failures++;
        end
      end
      if (data_gnt) begin
        exp_d = {32'hC0DE0000, 32'h3000 + 32'(8*beats)};
        checks++;
        if (data_dat !== exp_d || data_id !== 6'd3
            || data_last !== (beats == 7)) begin
          $display("FAIL burst_beat%0d got=%h %0d %b exp=%h 3 %b", beats,
                   data_dat, data_id, data_last, exp_d, beats == 7);
          failures++;
        end
        if (first < 0) first = c;
        else if (prev != c - 1) gaps++;
        prev = c;
        beats++;
      end
      step();
    end
    data_req = 1'b0;
    checks++;
    if (beats != 8 || gaps != 0 || first != 2) begin
      $display("FAIL burst_stream got=%0d %0d %0d exp=8 0 2",
               beats, gaps, first);
      failures++;
    end
  endtask

  task automatic test_partial();
    model_en = 1'b0;
    set_trans(2'b01, 32'h6000, 6'd1, 1'b1);
    mem_gnt = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || trans_gnt !== 2'b11) begin
      $display("FAIL partial01 got=%b %b exp=0 11", mem_req, trans_gnt);
      failures++;
    end
    step();
    trans_req = 2'b10;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      $display("FAIL partial10 got=%b exp=0", mem_req); failures++;
    end
    step();
    trans_req = 2'b00;
    #1;
    checks++;
    if (dut.outstanding !== 3'd0 || data_gnt !== 1'b0) begin
      $display("FAIL partial_state got=%0d %b exp=0 0",
               dut.outstanding, data_gnt);
      failures++;
    end
  endtask

  task automatic test_stray();
    model_en = 1'b0;
    man_valid = 1'b1;
    man_data = 64'h1111_2222_3333_4444;
    step();
    man_valid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || data_gnt !== 1'b0) begin
      $display("FAIL stray_err got=%b %b exp=1 0", err, data_gnt);
      failures++;
    end
    step();
    step();
    #1;
    checks++;
    if (err !== 1'b1 || data_gnt !== 1'b0) begin
      $display("FAIL stray_sticky got=%b %b exp=1 0", err, data_gnt);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    model_en = 1'b1;
    lat = 1;
    data_req = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      set_trans(2'b11, 32'h4000 + 32'(8*k), 6'(k + 1), 1'b0);
      step();
    end
    trans_req = 2'b00;
    step();
    step();
    #1;
    checks++;
    if (data_gnt !== 1'b1 || data_dat !== 64'hC0DE0000_00004000
        || data_id !== 6'd1 || dut.outstanding !== 3'd3) begin
      $display("FAIL mid_buffered got=%b %h %0d %0d exp=1 c0de000000004000 1 3",
               data_gnt, data_dat, data_id, dut.outstanding);
      failures++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (data_gnt !== 1'b0 || data_dat !== 64'h0 || data_id !== 6'h0
        || data_last !== 1'b0 || err !== 1'b0 || trans_gnt !== 2'b11) begin
      $display("FAIL mid_reset got=%b %h %h %b %b %b exp=0 0 0 0 0 11",
               data_gnt, data_dat, data_id, data_last, err, trans_gnt);
      failures++;
    end
    step();
    rst = 1'b0;
    step();
    set_trans(2'b11, 32'h5008, 6'd7, 1'b1);
    step();
    trans_req = 2'b00;
    step();
    #1;
    checks++;
    if (data_gnt !== 1'b1 || data_dat !== 64'hC0DE0000_00005008
        || data_id !== 6'd7 || data_last !== 1'b1 || err !== 1'b0) begin
      $display("FAIL mid_after got=%b %h %0d %b %b exp=1 c0de000000005008 7 1 0",
               data_gnt, data_dat, data_id, data_last, err);
      failures++;
    end
    data_req = 1'b1;
    step();
    data_req = 1'b0;
    #1;
    checks++;
    if (data_gnt !== 1'b0) begin
      $display("FAIL mid_pop got=%b exp=0", data_gnt); failures++;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_en = 1'b0;
    lat = 1;
    man_valid = 1'b0;
    man_data = '0;
    test_reset();
    test_single();
    test_credit_stall();
    test_back_to_back();
    test_partial();
    test_stray();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
